bf_envelope_log: RTL and testbench

// Downstream stage of the beamformer top (top_bf): consumes signed beamformed sums, forms an envelope
// (rectify + peak-hold with exponential decay) and log-compresses it to 8-bit B-mode pixels.

---
 rtl/bf_envelope_log.sv | 143 ++++++++++++++
 tb/tb_bf_envelope_log.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_envelope_log.sv
// B-mode envelope/log stage: rectify, peak-hold envelope with exponential decay,
// log2-style compression to 8-bit pixels; 3-stage stall pipeline with scanline tagging.
module bf_envelope_log #(
    parameter int unsigned SUM_WIDTH        = 20,
    parameter int unsigned DECAY_SHIFT      = 3,
    parameter int unsigned SAMPLES_PER_LINE = 256
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [SUM_WIDTH-1:0] bf_sample_i,
    input  logic                 bf_valid_i,
    output logic                 bf_ready_o,
    output logic [7:0]           pix_data_o,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic                 pix_last_o,
    output logic [15:0]          line_count_o
);

    localparam int unsigned ABS_W = SUM_WIDTH - 1;
    localparam int unsigned CNT_W = (SAMPLES_PER_LINE > 1) ? $clog2(SAMPLES_PER_LINE) : 1;
    localparam int unsigned P_W   = $clog2(ABS_W);

    logic                 adv_c;
    logic                 accept_c;
    logic [SUM_WIDTH-1:0] mag_c;
    logic [ABS_W-1:0]     abs_c;
    logic                 cnt_last_c;

    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic [ABS_W-1:0]     s1_abs_q;
    logic                 s2_valid_q;
    logic                 s2_last_q;
    logic [ABS_W-1:0]     env_q,        env_d;
    logic                 clr_q;
    logic [ABS_W-1:0]     decay_c;
    logic [ABS_W-1:0]     base_c;
    logic [P_W-1:0]       lead_c;
    logic [P_W-1:0]       shamt_c;
    logic [ABS_W-1:0]     norm_c;
    logic [2:0]           frac_c;
    logic [15:0]          code_c;
    logic [7:0]           pix_data_q,   pix_data_d;
    logic                 pix_valid_q;
    logic                 pix_last_q;
    logic [15:0]          line_count_q, line_count_d;

    // Whole pipe moves together; only a stalled output pixel holds it.
    assign adv_c      = !pix_valid_q || pix_ready_i;
    assign accept_c   = bf_valid_i && adv_c;
    assign bf_ready_o = adv_c;

    // Rectify; the most negative input has no positive twin and saturates.
    always_comb begin
        mag_c = bf_sample_i[SUM_WIDTH-1] ? (~bf_sample_i + SUM_WIDTH'(1)) : bf_sample_i;
        abs_c = mag_c[SUM_WIDTH-1] ? {ABS_W{1'b1}} : mag_c[ABS_W-1:0];
    end

    always_comb begin
        cnt_last_c = (cnt_q == CNT_W'(SAMPLES_PER_LINE - 1));
        cnt_d      = cnt_q;
        if (accept_c) begin
            cnt_d = cnt_last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Peak-hold with decay; a pending end-of-line clear overrides the decayed value.
    always_comb begin
        decay_c = env_q - (env_q >> DECAY_SHIFT);
        base_c  = clr_q ? '0 : decay_c;
        env_d   = (s1_abs_q >= base_c) ? s1_abs_q : base_c;
    end

    // Log compression: leading-one position as integer part, next three bits as fraction.
    always_comb begin
        lead_c = '0;
        for (int unsigned i = 0; i < ABS_W; i++) begin
            if (env_q[i]) begin
                lead_c = P_W'(i);
            end
        end
        shamt_c = P_W'(ABS_W - 1) - lead_c;
        norm_c  = env_q << shamt_c;
        frac_c  = 3'(norm_c >> (ABS_W - 4));
        code_c  = 16'({lead_c, frac_c});
        if (env_q == '0) begin
            pix_data_d = 8'd0;
        end else if (code_c > 16'd255) begin
            pix_data_d = 8'hFF;
        end else begin
            pix_data_d = code_c[7:0];
        end
    end

    always_comb begin
        line_count_d = line_count_q;
        if (pix_valid_q && pix_ready_i && pix_last_q) begin
            line_count_d = line_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_abs_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            env_q        <= '0;
            clr_q        <= 1'b0;
            pix_data_q   <= 8'd0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            line_count_q <= 16'd0;
        end else begin
            cnt_q        <= cnt_d;
            line_count_q <= line_count_d;
            if (adv_c) begin
                s1_valid_q  <= accept_c;
                s1_last_q   <= accept_c && cnt_last_c;
                s1_abs_q    <= abs_c;
                s2_valid_q  <= s1_valid_q;
                s2_last_q   <= s1_last_q;
                pix_valid_q <= s2_valid_q;
                pix_last_q  <= s2_last_q;
                pix_data_q  <= pix_data_d;
                if (s1_valid_q) begin
                    env_q <= env_d;
                    clr_q <= s1_last_q;
                end
            end
        end
    end

    assign pix_data_o   = pix_data_q;
    assign pix_valid_o  = pix_valid_q;
    assign pix_last_o   = pix_last_q;
    assign line_count_o = line_count_q;

endmodule

// File: tb/tb_bf_envelope_log.sv
// Directed bench for bf_envelope_log: latency, envelope/log values, saturation,
// decay, a full scanline under backpressure, and mid-line reset.
module tb_bf_envelope_log;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] bf_sample = '0;
    logic        bf_valid = 1'b0;
    logic        bf_ready;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_last;
    logic [15:0] line_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] pq[$];
    logic [8:0] eq[$];
    int  m_env, m_cnt;
    bit  m_clr;
    bit  bp_en = 1'b0;
    int  bp_viol = 0;
    int  hold_viol = 0;
    int  lc_at_last = -1;
    bit  prev_stall = 1'b0;
    logic [8:0] prev_out = '0;

    bf_envelope_log dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .bf_sample_i  (bf_sample),
        .bf_valid_i   (bf_valid),
        .bf_ready_o   (bf_ready),
        .pix_data_o   (pix_data),
        .pix_valid_o  (pix_valid),
        .pix_ready_i  (pix_ready),
        .pix_last_o   (pix_last),
        .line_count_o (line_count)
    );

    initial forever #5 clk = ~clk;

    // Random backpressure while enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) pix_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: collects transfers, checks stall behaviour.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
                pq.push_back({pix_last, pix_data});
                if (pix_last === 1'b1) lc_at_last = int'(line_count);
            end
            if (pix_valid === 1'b1 && pix_ready === 1'b0 && bf_ready !== 1'b0) bp_viol++;
            if (prev_stall && {pix_last, pix_data} !== prev_out) hold_viol++;
            prev_stall = (pix_valid === 1'b1 && pix_ready === 1'b0);
            prev_out   = {pix_last, pix_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pix(input int env);
        int p;
        int code;
        if (env == 0) return 0;
        p = 0;
        while ((env >> (p + 1)) != 0) p++;
        code = 8 * p + (((env << 3) >> p) - 8);
        return (code > 255) ? 255 : code;
    endfunction

    task automatic model_step(input logic [19:0] s);
        int sv, a, d, base;
        bit last;
        sv = int'(signed'(s));
        a  = (sv < 0) ? -sv : sv;
        if (a > 524287) a = 524287;
        d    = m_env - (m_env >> 3);
        base = m_clr ? 0 : d;
        m_env = (a >= base) ? a : base;
        last  = (m_cnt == 255);
        eq.push_back({last, 8'(ref_pix(m_env))});
        m_clr = last;
        m_cnt = last ? 0 : m_cnt + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bf_valid = 1'b0;
        bf_sample = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pq.delete();
        eq.delete();
        m_env = 0;
        m_cnt = 0;
        m_clr = 1'b0;
    endtask

    task automatic send(input logic [19:0] s);
        int  t;
        bit  acc;
        model_step(s);
        bf_sample = s;
        bf_valid  = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = (bf_ready === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        bf_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_pix(input string tag, input int n);
        int t;
        t = 0;
        while (pq.size() < n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(tag, pq.size(), n);
    endtask

    task automatic check_stream(input string tag);
        for (int i = 0; i < eq.size(); i++) begin
            chk($sformatf("%s_px%0d", tag, i), (i < pq.size()) ? int'(pq[i]) : -1, int'(eq[i]));
        end
    endtask

    int t4_exp[11] = '{80, 78, 76, 74, 73, 72, 70, 68, 67, 65, 64};

    initial begin
        do_reset();
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_pix_last", int'(pix_last), 0);
        chk("rst_line_count", int'(line_count), 0);
        chk("rst_bf_ready", int'(bf_ready), 1);

        // T1: latency of a single +16 sample.
        bf_sample = 20'd16;
        bf_valid  = 1'b1;
        @(posedge clk); #1;
        bf_valid = 1'b0;
        chk("t1_valid_n1", int'(pix_valid), 0);
        @(posedge clk); #1;
        chk("t1_valid_n2", int'(pix_valid), 0);
        @(posedge clk); #1;
        chk("t1_valid_n3", int'(pix_valid), 1);
        chk("t1_data", int'(pix_data), 32);
        chk("t1_last", int'(pix_last), 0);
        @(posedge clk); #1;
        chk("t1_valid_n4", int'(pix_valid), 0);

        // T2: -16 then 0 -> env 16, 14.
        do_reset();
        send(20'hFFFF0);
        send(20'd0);
        wait_pix("t2_count", 2);
        chk("t2_p0", int'(pq[0]), 32);
        chk("t2_p1", int'(pq[1]), 30);

        do_reset();
        send(20'd3);
        wait_pix("t2_three_count", 1);
        chk("t2_three", int'(pq[0]), 12);

        do_reset();
        send(20'd0);
        wait_pix("t2_zero_count", 1);
        chk("t2_zero", int'(pq[0]), 0);

        // T3: most negative and most positive inputs.
        do_reset();
        send(20'h80000);
        send(20'h7FFFF);
        wait_pix("t3_count", 2);
        chk("t3_neg_sat", int'(pq[0]), 151);
        chk("t3_pos_max", int'(pq[1]), 151);

        // T4: 1024 then ten zeros decays.
        do_reset();
        send(20'd1024);
        for (int i = 0; i < 10; i++) send(20'd0);
        wait_pix("t4_count", 11);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t4_px%0d", i), int'(pq[i]), t4_exp[i]);
        end

        // T5: full scanline with random backpressure.
        do_reset();
        lc_at_last = -1;
        bp_viol = 0;
        hold_viol = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int v;
            v = (i % 16 == 15) ? 0 : i * 300 + 5;
            send((i % 2 == 1) ? 20'(-v) : 20'(v));
        end
        wait_pix("t5_count", 256);
        bp_en = 1'b0;
        @(posedge clk); #1;
        pix_ready = 1'b1;
        check_stream("t5");
        chk("t5_lc_before", lc_at_last, 0);
        chk("t5_lc_after", int'(line_count), 1);
        chk("t5_bp_ready", bp_viol, 0);
        chk("t5_hold", hold_viol, 0);

        // T6: reset with three samples in flight.
        send(20'd100);
        send(20'd200);
        send(20'd300);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid", int'(pix_valid), 0);
        chk("t6_line_count", int'(line_count), 0);
        reset = 1'b0;
        pq.delete();
        eq.delete();
        m_env = 0;
        m_cnt = 0;
        m_clr = 1'b0;
        send(20'd16);
        for (int i = 1; i < 256; i++) send(20'(i % 7));
        wait_pix("t6_count", 256);
        chk("t6_first", int'(pq[0]), 32);
        check_stream("t6");
        chk("t6_line_count_end", int'(line_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
